// File: rtl/lc3_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lc3Pkg
// Brief   : Shared types for the LC-3 memory arbiter (FSM states, requesters).
// Revision: 1.0 - initial release
// ============================================================================
package lc3Pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_DONE   = 2'd2
    } arb_state_e;

    typedef enum logic [0:0] {
        REQ_CPU = 1'b0,
        REQ_IO  = 1'b1
    } req_src_e;

    localparam int unsigned C_WAIT_W = 8;

endpackage
`default_nettype wire

// File: rtl/lc3_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : lc3_rr_pick
// Brief   : Two-way round-robin winner selection (combinational).
// Revision: 1.0 - initial release
// ============================================================================
module lc3_rr_pick
    import lc3Pkg::*;
(
    input  logic     i_cpu_req,
    input  logic     i_io_req,
    input  req_src_e i_last_grant,
    output logic     o_valid,
    output req_src_e o_winner
);

    always_comb begin
        o_valid  = i_cpu_req | i_io_req;
        o_winner = REQ_CPU;
        if (i_cpu_req && i_io_req) begin
            o_winner = (i_last_grant == REQ_IO) ? REQ_CPU : REQ_IO;
        end else if (i_io_req) begin
            o_winner = REQ_IO;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : lc3_mem_arbiter
// Brief   : Round-robin CPU/IO memory arbiter with wait-state timeout.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_mem_arbiter
    import lc3Pkg::*;
#(
    parameter int AW      = 16,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_done,
    input  logic          io_req,
    input  logic          io_we,
    input  logic [AW-1:0] io_addr,
    input  logic [DW-1:0] io_wdata,
    output logic          io_done,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready
);

    localparam logic [C_WAIT_W-1:0] C_WAIT_LAST = C_WAIT_W'(TIMEOUT - 1);

    arb_state_e          r_state_q,     w_state_d;
    req_src_e            r_last_q,      w_last_d;
    req_src_e            r_winner_q,    w_winner_d;
    logic [C_WAIT_W-1:0] r_wait_q,      w_wait_d;
    logic                r_cpu_done_q,  w_cpu_done_d;
    logic                r_io_done_q,   w_io_done_d;
    logic [DW-1:0]       r_rdata_q,     w_rdata_d;
    logic                r_err_q,       w_err_d;
    logic                r_mem_en_q,    w_mem_en_d;
    logic                r_mem_we_q,    w_mem_we_d;
    logic [AW-1:0]       r_mem_addr_q,  w_mem_addr_d;
    logic [DW-1:0]       r_mem_wdata_q, w_mem_wdata_d;

    logic     w_pick_valid;
    req_src_e w_pick;

    lc3_rr_pick u_rr_pick (
        .i_cpu_req    (cpu_req),
        .i_io_req     (io_req),
        .i_last_grant (r_last_q),
        .o_valid      (w_pick_valid),
        .o_winner     (w_pick)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_last_d      = r_last_q;
        w_winner_d    = r_winner_q;
        w_wait_d      = r_wait_q;
        w_cpu_done_d  = 1'b0;
        w_io_done_d   = 1'b0;
        w_rdata_d     = r_rdata_q;
        w_err_d       = r_err_q;
        w_mem_en_d    = r_mem_en_q;
        w_mem_we_d    = r_mem_we_q;
        w_mem_addr_d  = r_mem_addr_q;
        w_mem_wdata_d = r_mem_wdata_q;

        case (r_state_q)
            ARB_IDLE: begin
                if (w_pick_valid) begin
                    w_state_d  = ARB_ACCESS;
                    w_winner_d = w_pick;
                    w_wait_d   = '0;
                    w_mem_en_d = 1'b1;
                    if (w_pick == REQ_CPU) begin
                        w_mem_we_d    = cpu_we;
                        w_mem_addr_d  = cpu_addr;
                        w_mem_wdata_d = cpu_wdata;
                    end else begin
                        w_mem_we_d    = io_we;
                        w_mem_addr_d  = io_addr;
                        w_mem_wdata_d = io_wdata;
                    end
                end
            end
            ARB_ACCESS: begin
                // A late ready in the timeout cycle still counts as success.
                if (mem_ready || (r_wait_q == C_WAIT_LAST)) begin
                    w_state_d     = ARB_DONE;
                    w_err_d       = ~mem_ready;
                    w_rdata_d     = (mem_ready && !r_mem_we_q) ? mem_rdata : '0;
                    w_cpu_done_d  = (r_winner_q == REQ_CPU);
                    w_io_done_d   = (r_winner_q == REQ_IO);
                    w_mem_en_d    = 1'b0;
                    w_mem_we_d    = 1'b0;
                    w_mem_addr_d  = '0;
                    w_mem_wdata_d = '0;
                end else begin
                    w_wait_d = r_wait_q + 1'b1;
                end
            end
            ARB_DONE: begin
                w_state_d = ARB_IDLE;
                w_last_d  = r_winner_q;
            end
            default: begin
                w_state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q     <= ARB_IDLE;
            r_last_q      <= REQ_IO;
            r_winner_q    <= REQ_CPU;
            r_wait_q      <= '0;
            r_cpu_done_q  <= 1'b0;
            r_io_done_q   <= 1'b0;
            r_rdata_q     <= '0;
            r_err_q       <= 1'b0;
            r_mem_en_q    <= 1'b0;
            r_mem_we_q    <= 1'b0;
            r_mem_addr_q  <= '0;
            r_mem_wdata_q <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_last_q      <= w_last_d;
            r_winner_q    <= w_winner_d;
            r_wait_q      <= w_wait_d;
            r_cpu_done_q  <= w_cpu_done_d;
            r_io_done_q   <= w_io_done_d;
            r_rdata_q     <= w_rdata_d;
            r_err_q       <= w_err_d;
            r_mem_en_q    <= w_mem_en_d;
            r_mem_we_q    <= w_mem_we_d;
            r_mem_addr_q  <= w_mem_addr_d;
            r_mem_wdata_q <= w_mem_wdata_d;
        end
    end

    assign cpu_done  = r_cpu_done_q;
    assign io_done   = r_io_done_q;
    assign rdata     = r_rdata_q;
    assign err       = r_err_q;
    assign mem_en    = r_mem_en_q;
    assign mem_we    = r_mem_we_q;
    assign mem_addr  = r_mem_addr_q;
    assign mem_wdata = r_mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_mem_arbiter
// Brief   : Directed self-checking bench for lc3_mem_arbiter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3_mem_arbiter;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, io_req, io_we;
    logic [15:0] cpu_addr, cpu_wdata, io_addr, io_wdata;
    logic        cpu_done, io_done, err;
    logic [15:0] rdata;
    logic        mem_en, mem_we, mem_ready;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    lc3_mem_arbiter #(.AW(16), .DW(16), .TIMEOUT(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_done  (cpu_done),
        .io_req    (io_req),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_done   (io_done),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%04h expected=0x%04h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        io_req  = 0; io_we  = 0; io_addr  = 0; io_wdata  = 0;
        mem_ready = 0; mem_rdata = 0;

        // Reset state
        tick(); tick();
        chk("rst_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rst_cpu_done", {15'd0, cpu_done}, 16'd0);
        chk("rst_rdata", rdata, 16'h0000);
        chk("rst_err", {15'd0, err}, 16'd0);
        rst_n = 1'b1;

        // CPU-only read, ready in first ACCESS cycle
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        tick();
        chk("rd_mem_en", {15'd0, mem_en}, 16'd1);
        chk("rd_mem_addr", mem_addr, 16'h3000);
        chk("rd_mem_we", {15'd0, mem_we}, 16'd0);
        mem_ready = 1; mem_rdata = 16'h1234;
        tick();
        chk("rd_cpu_done", {15'd0, cpu_done}, 16'd1);
        chk("rd_io_done", {15'd0, io_done}, 16'd0);
        chk("rd_rdata", rdata, 16'h1234);
        chk("rd_err", {15'd0, err}, 16'd0);
        chk("rd_done_mem_en", {15'd0, mem_en}, 16'd0);
        chk("rd_done_mem_addr", mem_addr, 16'h0000);
        cpu_req = 0; mem_ready = 0;
        tick();
        chk("rd_idle_cpu_done", {15'd0, cpu_done}, 16'd0);
        chk("rd_idle_rdata_hold", rdata, 16'h1234);

        // Tie after reset: CPU first, then IO write, then CPU again
        rst_n = 0; tick(); rst_n = 1;
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h3000;
        io_req = 1; io_we = 1; io_addr = 16'hFE06; io_wdata = 16'h0041;
        tick();
        chk("tie1_addr", mem_addr, 16'h3000);
        chk("tie1_we", {15'd0, mem_we}, 16'd0);
        mem_ready = 1; mem_rdata = 16'h5555;
        tick();
        chk("tie1_cpu_done", {15'd0, cpu_done}, 16'd1);
        chk("tie1_io_done", {15'd0, io_done}, 16'd0);
        chk("tie1_rdata", rdata, 16'h5555);
        cpu_req = 0; mem_ready = 0;
        tick();
        chk("tie1_idle_en", {15'd0, mem_en}, 16'd0);
        tick();
        chk("io_wr_addr", mem_addr, 16'hFE06);
        chk("io_wr_we", {15'd0, mem_we}, 16'd1);
        chk("io_wr_wdata", mem_wdata, 16'h0041);
        mem_ready = 1; mem_rdata = 16'hDEAD;
        tick();
        chk("io_wr_io_done", {15'd0, io_done}, 16'd1);
        chk("io_wr_cpu_done", {15'd0, cpu_done}, 16'd0);
        chk("io_wr_rdata", rdata, 16'h0000);
        io_req = 0; mem_ready = 0;
        tick();
        cpu_req = 1; io_req = 1;
        tick();
        chk("tie2_addr", mem_addr, 16'h3000);
        mem_ready = 1; mem_rdata = 16'h0001;
        tick();
        chk("tie2_cpu_done", {15'd0, cpu_done}, 16'd1);
        cpu_req = 0; io_req = 0; mem_ready = 0;
        tick();

        // Wait states: ready after 5 stall cycles
        cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1111;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("ws_en", {15'd0, mem_en}, 16'd1);
            chk("ws_addr", mem_addr, 16'h1111);
            chk("ws_no_done", {15'd0, cpu_done}, 16'd0);
            tick();
        end
        chk("ws_en6", {15'd0, mem_en}, 16'd1);
        mem_ready = 1; mem_rdata = 16'hABCD;
        tick();
        chk("ws_done", {15'd0, cpu_done}, 16'd1);
        chk("ws_rdata", rdata, 16'hABCD);
        chk("ws_err", {15'd0, err}, 16'd0);
        cpu_req = 0; mem_ready = 0;
        tick();

        // Timeout with ready never asserted
        io_req = 1; io_we = 0; io_addr = 16'h2222;
        tick();
        for (int i = 0; i < 16; i++) begin
            chk("to_en", {15'd0, mem_en}, 16'd1);
            tick();
        end
        chk("to_en_off", {15'd0, mem_en}, 16'd0);
        chk("to_io_done", {15'd0, io_done}, 16'd1);
        chk("to_err", {15'd0, err}, 16'd1);
        chk("to_rdata", rdata, 16'h0000);
        io_req = 0;
        tick();
        chk("to_err_hold", {15'd0, err}, 16'd1);

        // Ready arrives in the 16th (timeout) cycle
        io_req = 1;
        tick();
        for (int i = 0; i < 15; i++) begin
            chk("to2_en", {15'd0, mem_en}, 16'd1);
            tick();
        end
        chk("to2_en16", {15'd0, mem_en}, 16'd1);
        mem_ready = 1; mem_rdata = 16'h7777;
        tick();
        chk("to2_io_done", {15'd0, io_done}, 16'd1);
        chk("to2_err", {15'd0, err}, 16'd0);
        chk("to2_rdata", rdata, 16'h7777);
        io_req = 0; mem_ready = 0;
        tick();

        // Reset mid-ACCESS: make last=CPU, then abort an IO access
        cpu_req = 1; cpu_addr = 16'h4444; io_req = 1; io_addr = 16'h5555;
        tick();
        chk("rm_cpu_first", mem_addr, 16'h4444);
        mem_ready = 1;
        tick();
        mem_ready = 0;
        tick();
        tick();
        chk("rm_io_access", mem_addr, 16'h5555);
        tick();
        chk("rm_io_access2", {15'd0, mem_en}, 16'd1);
        rst_n = 0;
        #1;
        chk("rm_en_async", {15'd0, mem_en}, 16'd0);
        tick();
        chk("rm_no_io_done", {15'd0, io_done}, 16'd0);
        chk("rm_no_cpu_done", {15'd0, cpu_done}, 16'd0);
        rst_n = 1;
        tick();
        chk("rm_post_tie_cpu", mem_addr, 16'h4444);
        mem_ready = 1;
        tick();
        chk("rm_post_cpu_done", {15'd0, cpu_done}, 16'd1);
        cpu_req = 0; io_req = 0; mem_ready = 0;
        tick();

        // Back-to-back IO transactions with ready held high
        io_req = 1; io_addr = 16'h6000; mem_ready = 1; mem_rdata = 16'h0F0F;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk("b2b_io_done", {15'd0, io_done}, (c % 3 == 2) ? 16'd1 : 16'd0);
            chk("b2b_cpu_done", {15'd0, cpu_done}, 16'd0);
            if (c == 8) io_req = 0;
        end
        mem_ready = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
